// File: rtl/product_bcd_converter_if.sv
// Handshake/data bundle between a product producer and the BCD converter.
interface product_bcd_converter_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  sign;

  modport master (output start, bin, input busy, done, bcd, sign);
  modport slave  (input start, bin, output busy, done, bcd, sign);
endinterface

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter with optional two's complement
// input; one conversion in flight, WIDTH cycles per result.
module product_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  product_bcd_converter_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, CONVERT = 1'b1} state_t;

  state_t            state_r;
  logic [WIDTH-1:0]  shift_r;
  logic [BW-1:0]     scratch_r;
  logic [CW-1:0]     count_r;
  logic              sign_lat_r;
  logic              busy_r;
  logic              done_r;
  logic              sign_r;
  logic [BW-1:0]     bcd_r;

  logic [BW-1:0]     adj_s;
  logic [BW-1:0]     scratch_next_s;
  logic [WIDTH-1:0]  shift_next_s;
  logic [WIDTH-1:0]  mag_s;
  logic              neg_s;
  logic              last_s;

  function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int d = 0; d < DIGITS; d++) begin
      if (v[4*d +: 4] >= 4'd5) begin
        r[4*d +: 4] = v[4*d +: 4] + 4'd3;
      end else begin
        r[4*d +: 4] = v[4*d +: 4];
      end
    end
    return r;
  endfunction

  // Input magnitude/sign extraction and one add-3-then-shift step
  always_comb begin
    neg_s          = 1'b0;
    mag_s          = bus.bin;
    adj_s          = add3_digits(scratch_r);
    scratch_next_s = {adj_s[BW-2:0], shift_r[WIDTH-1]};
    shift_next_s   = {shift_r[WIDTH-2:0], 1'b0};
    last_s         = (count_r == CW'(WIDTH - 1));
    if (SIGNED != 0) begin
      neg_s = bus.bin[WIDTH-1];
    end else begin
      neg_s = 1'b0;
    end
    // Most-negative input wraps to 2**(WIDTH-1), which is the correct magnitude
    if (neg_s) begin
      mag_s = (~bus.bin) + WIDTH'(1);
    end else begin
      mag_s = bus.bin;
    end
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      shift_r    <= {WIDTH{1'b0}};
      scratch_r  <= {BW{1'b0}};
      count_r    <= {CW{1'b0}};
      sign_lat_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      sign_r     <= 1'b0;
      bcd_r      <= {BW{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            shift_r    <= mag_s;
            sign_lat_r <= neg_s;
            scratch_r  <= {BW{1'b0}};
            count_r    <= {CW{1'b0}};
            busy_r     <= 1'b1;
            state_r    <= CONVERT;
          end else begin
            state_r    <= IDLE;
          end
        end
        CONVERT: begin
          scratch_r <= scratch_next_s;
          shift_r   <= shift_next_s;
          count_r   <= count_r + CW'(1);
          if (last_s) begin
            bcd_r   <= scratch_next_s;
            sign_r  <= sign_lat_r;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= CONVERT;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.bcd  = bcd_r;
  assign bus.sign = sign_r;
endmodule

// File: tb/tb_product_bcd_converter.sv
// Directed bench: signed and unsigned converters driven in lockstep, checked
// against hand-computed vectors and a division-based decimal model.
module tb_product_bcd_converter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;

  product_bcd_converter_if #(.WIDTH(8), .DIGITS(3)) if_s ();
  product_bcd_converter_if #(.WIDTH(8), .DIGITS(3)) if_u ();

  product_bcd_converter #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) dut_s (
    .clock(clock), .reset(reset), .bus(if_s));
  product_bcd_converter #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) dut_u (
    .clock(clock), .reset(reset), .bus(if_u));

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd_s;
    logic        sign_s;
    logic [11:0] bcd_u;
  } vec_t;

  vec_t vecs[9];

  task automatic drive(input logic s, input logic [7:0] v);
    if_s.start = s; if_s.bin = v;
    if_u.start = s; if_u.bin = v;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [11:0] ref_bcd(input logic [7:0] v, input bit sgn);
    int m;
    m = int'(v);
    if (sgn && v[7]) m = 256 - m;
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // One conversion: start for one cycle, then watch both DUTs until done (bounded)
  task automatic run_conv(input logic [7:0] v, output int lat_s, output int lat_u,
                          output int busy_n, output int glitch);
    logic [11:0] prev_s;
    logic [11:0] prev_u;
    lat_s = -1; lat_u = -1; busy_n = 0; glitch = 0;
    @(negedge clock);
    prev_s = if_s.bcd; prev_u = if_u.bcd;
    drive(1'b1, v);
    @(posedge clock);
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (c == 0) drive(1'b0, 8'd0);
      if (if_s.busy) busy_n++;
      if (!if_s.done && if_s.bcd !== prev_s) glitch++;
      if (!if_u.done && if_u.bcd !== prev_u) glitch++;
      if (if_u.done && lat_u < 0) lat_u = c;
      if (if_s.done) begin
        lat_s = c;
        break;
      end
    end
  endtask

  initial begin
    int ls, lu, bn, gl, dones;
    vecs[0] = '{8'd0,   12'h000, 1'b0, 12'h000};
    vecs[1] = '{8'd255, 12'h001, 1'b1, 12'h255};
    vecs[2] = '{8'hF1,  12'h015, 1'b1, 12'h241};
    vecs[3] = '{8'h80,  12'h128, 1'b1, 12'h128};
    vecs[4] = '{8'h7F,  12'h127, 1'b0, 12'h127};
    vecs[5] = '{8'd99,  12'h099, 1'b0, 12'h099};
    vecs[6] = '{8'd42,  12'h042, 1'b0, 12'h042};
    vecs[7] = '{8'd200, 12'h056, 1'b1, 12'h200};
    vecs[8] = '{8'd7,   12'h007, 1'b0, 12'h007};

    drive(1'b0, 8'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_busy", {31'd0, if_s.busy | if_u.busy}, 32'd0);
    check("rst_done", {31'd0, if_s.done | if_u.done}, 32'd0);
    check("rst_bcd_s", {20'd0, if_s.bcd}, 32'd0);
    check("rst_bcd_u", {20'd0, if_u.bcd}, 32'd0);
    check("rst_sign", {31'd0, if_s.sign | if_u.sign}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i].bin, ls, lu, bn, gl);
      check($sformatf("vec%0d_lat_s", i), ls, 32'd8);
      check($sformatf("vec%0d_lat_u", i), lu, 32'd8);
      check($sformatf("vec%0d_busy", i), bn, 32'd8);
      check($sformatf("vec%0d_hold", i), gl, 32'd0);
      check($sformatf("vec%0d_bcd_s", i), {20'd0, if_s.bcd}, {20'd0, vecs[i].bcd_s});
      check($sformatf("vec%0d_sign_s", i), {31'd0, if_s.sign}, {31'd0, vecs[i].sign_s});
      check($sformatf("vec%0d_bcd_u", i), {20'd0, if_u.bcd}, {20'd0, vecs[i].bcd_u});
      check($sformatf("vec%0d_sign_u", i), {31'd0, if_u.sign}, 32'd0);
    end

    // start while busy is ignored; start in the done cycle is accepted
    @(negedge clock);
    drive(1'b1, 8'd99);
    @(posedge clock);
    dones = 0;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clock);
      if (c == 0) drive(1'b0, 8'd0);
      if (c == 2) drive(1'b1, 8'd42);
      if (c == 3) drive(1'b0, 8'd0);
      if (if_s.done) dones++;
    end
    check("ign_single_done", dones, 32'd1);
    check("ign_done_at_8", {31'd0, if_s.done}, 32'd1);
    check("ign_bcd", {20'd0, if_s.bcd}, 32'h099);
    drive(1'b1, 8'd42);
    @(posedge clock);
    ls = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (c == 0) begin
        drive(1'b0, 8'd0);
        check("b2b_busy", {31'd0, if_s.busy}, 32'd1);
        check("b2b_done_low", {31'd0, if_s.done}, 32'd0);
      end
      if (if_s.done) begin
        ls = c;
        break;
      end
    end
    check("b2b_lat", ls, 32'd8);
    check("b2b_bcd", {20'd0, if_s.bcd}, 32'h042);

    // reset mid-conversion aborts without a done pulse
    @(negedge clock);
    drive(1'b1, 8'd200);
    @(posedge clock);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (c == 0) drive(1'b0, 8'd0);
      if (c == 3) reset = 1'b1;
    end
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", {31'd0, if_s.busy | if_u.busy}, 32'd0);
    check("abort_done", {31'd0, if_s.done | if_u.done}, 32'd0);
    check("abort_bcd", {20'd0, if_s.bcd}, 32'd0);
    check("abort_sign", {31'd0, if_s.sign}, 32'd0);
    dones = 0;
    repeat (12) begin
      @(negedge clock);
      if (if_s.done || if_u.done) dones++;
    end
    check("abort_no_done", dones, 32'd0);
    run_conv(8'd7, ls, lu, bn, gl);
    check("fresh_lat", ls, 32'd8);
    check("fresh_bcd", {20'd0, if_s.bcd}, 32'h007);

    // full sweep against the decimal model
    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), ls, lu, bn, gl);
      check($sformatf("sw%0d_lat", v), ls, 32'd8);
      check($sformatf("sw%0d_bcd_s", v), {20'd0, if_s.bcd}, {20'd0, ref_bcd(8'(v), 1'b1)});
      check($sformatf("sw%0d_sign_s", v), {31'd0, if_s.sign}, {31'd0, (v >= 128) ? 1'b1 : 1'b0});
      check($sformatf("sw%0d_bcd_u", v), {20'd0, if_u.bcd}, {20'd0, ref_bcd(8'(v), 1'b0)});
      check($sformatf("sw%0d_sign_u", v), {31'd0, if_u.sign}, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
